uart_mem_cmd_sequencer: RTL and testbench

- Parses a byte stream from the UART receiver into memory read/write transactions and issues them to the async Micron cellular-RAM controller over a req/ack handshake.
- Serializes read data back out through the UART transmitter.
- Sits between uart_rx/uart_tx and the async SRAM controller in the board-level debug/bring-up top.
- Protocol: command byte (0x56 write, 0x55 read), 4 address bytes, then 4 data bytes for a write only. All multi-byte fields are little-endian, byte 0 = LSBs.

---
 rtl/uart_mem_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_uart_mem_cmd_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_cmd_sequencer.sv
// UART byte-stream to memory transaction sequencer: parses 0x56/0x55 commands, drives
// a req/ack memory port and returns read data over UART. Optional inter-byte timeout: UART_MEM_TIMEOUT_EN.
module uart_mem_cmd_sequencer #(
    parameter logic [7:0] WRITE_CMD      = 8'h56,
    parameter logic [7:0] READ_CMD       = 8'h55,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk50MHz,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        overrun,
    output logic [7:0]  debug_out
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR    = 4'd1,
        S_WDATA   = 4'd2,
        S_MEM_REQ = 4'd3,
        S_TX_LOAD = 4'd4,
        S_TX_WAIT = 4'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_cnt;
    logic [31:0] rd_buf;
    logic        wait_first;
    logic        timeout_hit;
    logic        abort_pulse;

    logic in_parse;
    logic accept_cmd;
    logic load_addr;
    logic load_wdata;
    logic mem_done;
    logic tx_launch;
    logic tx_next;
    logic drop_byte;

    // Handshakes: rx_valid is a one-cycle strobe with no back-pressure (bytes outside the
    // parse states are dropped and flagged); mem_req stays high with addr/wdata/we stable
    // until the one-cycle mem_ack; tx_start is a one-cycle strobe issued only when tx_busy is low.

    always_ff @(posedge clk50MHz) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (accept_cmd) state_next = S_ADDR;
            S_ADDR: begin
                if (load_addr && byte_cnt == 2'd3) state_next = mem_we ? S_WDATA : S_MEM_REQ;
                else if (timeout_hit)              state_next = S_IDLE;
            end
            S_WDATA: begin
                if (load_wdata && byte_cnt == 2'd3) state_next = S_MEM_REQ;
                else if (timeout_hit)               state_next = S_IDLE;
            end
            S_MEM_REQ: if (mem_done)  state_next = mem_we ? S_IDLE : S_TX_LOAD;
            S_TX_LOAD: if (tx_launch) state_next = S_TX_WAIT;
            S_TX_WAIT: if (tx_next)   state_next = (byte_cnt == 2'd3) ? S_IDLE : S_TX_LOAD;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_parse   = (state == S_IDLE) || (state == S_ADDR) || (state == S_WDATA);
        accept_cmd = (state == S_IDLE) && rx_valid &&
                     ((rx_data == WRITE_CMD) || (rx_data == READ_CMD));
        load_addr  = (state == S_ADDR) && rx_valid;
        load_wdata = (state == S_WDATA) && rx_valid;
        mem_done   = (state == S_MEM_REQ) && mem_req && mem_ack;
        tx_launch  = (state == S_TX_LOAD) && !tx_busy;
        // The first TX_WAIT cycle is skipped so the UART has time to raise tx_busy.
        tx_next    = (state == S_TX_WAIT) && !wait_first && !tx_busy;
        drop_byte  = rx_valid && !in_parse;
    end

    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            overrun    <= 1'b0;
            byte_cnt   <= '0;
            rd_buf     <= '0;
            wait_first <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            mem_req  <= (state == S_MEM_REQ) && !mem_done;
            if (accept_cmd) begin
                mem_we   <= (rx_data == WRITE_CMD);
                byte_cnt <= 2'd0;
            end
            if (load_addr) begin
                mem_addr[{byte_cnt, 3'b000} +: 8] <= rx_data;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (load_wdata) begin
                mem_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (mem_done && !mem_we) begin
                rd_buf   <= mem_rdata;
                byte_cnt <= 2'd0;
            end
            if (state == S_TX_WAIT) wait_first <= 1'b0;
            if (tx_launch) begin
                tx_data    <= rd_buf[{byte_cnt, 3'b000} +: 8];
                tx_start   <= 1'b1;
                wait_first <= 1'b1;
            end
            if (tx_next && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
            if (drop_byte) overrun <= 1'b1;
        end
    end

`ifdef UART_MEM_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Counts idle cycles between bytes of a command; any accepted byte restarts it.
    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            to_cnt      <= '0;
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= timeout_hit;
            if (!((state == S_ADDR) || (state == S_WDATA)) || rx_valid) to_cnt <= '0;
            else                                                        to_cnt <= to_cnt + 32'd1;
        end
    end

    assign timeout_hit = ((state == S_ADDR) || (state == S_WDATA)) && !rx_valid &&
                         (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout_hit           = 1'b0;
    assign abort_pulse           = 1'b0;
`endif

    assign debug_out = {overrun, abort_pulse, byte_cnt, state};

endmodule

// File: tb/tb_uart_mem_cmd_sequencer.sv
// Directed bench for uart_mem_cmd_sequencer: write, read, junk/overrun, reset mid-op,
// back-to-back write/read and (with UART_MEM_TIMEOUT_EN) the inter-byte timeout.
module tb_uart_mem_cmd_sequencer;

    logic        clk50MHz = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        overrun;
    logic [7:0]  debug_out;

    int          n_checks = 0;
    int          n_errors = 0;
    int          busy_cnt = 0;
    logic        overlap_seen = 1'b0;
    logic [7:0]  tx_log[$];
    logic [7:0]  exp_q[$];
    logic [31:0] mem_model = '0;

    uart_mem_cmd_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .clk50MHz (clk50MHz),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .overrun  (overrun),
        .debug_out(debug_out)
    );

    always #10 clk50MHz = ~clk50MHz;

    // UART transmitter model: busy for four cycles after each tx_start, logs every byte.
    always @(posedge clk50MHz) begin
        #2;
        if (rst) begin
            busy_cnt = 0;
        end else if (tx_start) begin
            if (busy_cnt != 0) overlap_seen = 1'b1;
            tx_log.push_back(tx_data);
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = (busy_cnt != 0);
    end

    task automatic step();
        @(posedge clk50MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic ack(input logic [31:0] rdata);
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int k = 0;
        while (debug_out[3:0] != 4'd0 && k < max_cycles) begin
            step();
            k++;
        end
        check(tag, debug_out[3:0], 32'd0);
    endtask

    task automatic check_tx(input string tag, input logic [31:0] word);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(word[8*i +: 8]);
        check({tag, "_count"}, tx_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) check({tag, "_byte"}, tx_log[i], exp_q[i]);
        check({tag, "_no_overlap"}, overlap_seen, 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (3) step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_tx", {tx_start, tx_data}, 0);
        check("rst_debug", debug_out, 0);
        rst = 1'b0;
        step();

        // Junk byte in IDLE
        send_byte(8'hA5);
        check("junk_debug", debug_out, 8'h00);

        // Write 0x00FF00FF to 0x30
        send_byte(8'h56);
        check("wr_cmd_debug", debug_out, 8'h01);
        send_byte(8'h30);
        check("wr_addr0_debug", debug_out, 8'h11);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("wr_to_wdata", debug_out, 8'h02);
        send_word(32'h00FF00FF);
        check("wr_memreq_state", debug_out[3:0], 3);
        check("wr_req_not_yet", mem_req, 0);
        step();
        check("wr_req_high", mem_req, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 32'h00000030);
        check("wr_wdata", mem_wdata, 32'h00FF00FF);
        repeat (3) step();
        check("wr_req_held", mem_req, 1);
        check("wr_addr_held", mem_addr, 32'h00000030);
        check("wr_wdata_held", mem_wdata, 32'h00FF00FF);
        mem_model = 32'h00FF00FF;
        ack(32'hDEADBEEF);
        check("wr_req_drop", mem_req, 0);
        check("wr_idle", debug_out[3:0], 0);
        check("wr_addr_kept", mem_addr, 32'h00000030);
        repeat (8) step();
        check("wr_no_tx", tx_log.size(), 0);

        // Read from 0x31 with an early ack and an overrun byte
        send_byte(8'h55);
        send_word(32'h00000031);
        check("rd_memreq_state", debug_out[3:0], 3);
        mem_rdata = 32'hBADBAD00;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
        check("rd_early_ack_ignored", debug_out[3:0], 3);
        check("rd_req_high", mem_req, 1);
        check("rd_we", mem_we, 0);
        check("rd_addr", mem_addr, 32'h00000031);
        send_byte(8'h77);
        check("rd_overrun", overrun, 1);
        check("rd_still_memreq", debug_out[3:0], 3);
        ack(32'h12345678);
        check("rd_tx_load", debug_out[3:0], 4);
        check("rd_req_drop", mem_req, 0);
        step();
        check("rd_first_start", tx_start, 1);
        check("rd_first_data", tx_data, 8'h78);
        step();
        check("rd_start_pulse", tx_start, 0);
        wait_idle("rd_back_idle", 200);
        check_tx("rd_tx", 32'h12345678);
        check("rd_final_debug", debug_out, 8'hB0);

        // Reset in MEM_REQ, then a clean write
        send_byte(8'h56);
        send_word(32'h00000040);
        send_word(32'hA1B2C3D4);
        step();
        check("mid_req_high", mem_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_req_drop", mem_req, 0);
        check("mid_debug", debug_out, 8'h00);
        check("mid_addr_clr", mem_addr, 0);
        tx_log.delete();
        send_byte(8'h56);
        send_word(32'h00000030);
        send_word(32'h00FF00FF);
        step();
        check("wr2_req", {mem_req, mem_we}, 2'b11);
        check("wr2_addr", mem_addr, 32'h00000030);
        check("wr2_wdata", mem_wdata, 32'h00FF00FF);
        mem_model = 32'h00FF00FF;
        ack(32'h0);
        check("wr2_idle", debug_out[3:0], 0);

        // Read back the same address
        send_byte(8'h55);
        send_word(32'h00000030);
        step();
        check("rd2_req", {mem_req, mem_we}, 2'b10);
        check("rd2_addr", mem_addr, 32'h00000030);
        ack(mem_model);
        wait_idle("rd2_back_idle", 200);
        check_tx("rd2_tx", 32'h00FF00FF);
        check("rd2_no_overrun", overrun, 0);

`ifdef UART_MEM_TIMEOUT_EN
        // Abort after 100 idle cycles mid-address, then a working read
        tx_log.delete();
        send_byte(8'h56);
        send_byte(8'h30);
        repeat (99) step();
        check("to_not_yet", debug_out[3:0], 1);
        check("to_no_pulse_yet", debug_out[6], 0);
        step();
        check("to_idle", debug_out[3:0], 0);
        check("to_pulse", debug_out[6], 1);
        check("to_no_req", mem_req, 0);
        step();
        check("to_pulse_end", debug_out[6], 0);
        send_byte(8'h55);
        send_word(32'h00000031);
        step();
        check("to_rd_addr", mem_addr, 32'h00000031);
        ack(32'hCAFEF00D);
        wait_idle("to_rd_idle", 200);
        check_tx("to_rd_tx", 32'hCAFEF00D);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
